// File: rtl/pll_reset_sequencer.sv
// PLL lock qualifier and staged reset release.
// After the lock has been stable for a set interval, the system reset is released first and the UART reset follows a fixed gap later.
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 85000,
  parameter int unsigned RELEASE_GAP_CYCLES = 16,
  parameter int unsigned CNT_WIDTH          = 20,
  parameter int unsigned LOSS_CNT_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pll_lock,
  input  logic                      loss_clear,
  output logic                      sys_reset_n,
  output logic                      uart_reset_n,
  output logic                      ready,
  output logic                      lock_loss_flag,
  output logic [LOSS_CNT_WIDTH-1:0] lock_loss_count
);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, GAP, RUN} state_t;

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(RELEASE_GAP_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 lock_meta, lock_s;
  logic                 loss_event;

  // pll_lock is asynchronous to clk, so it goes through two flops before any decision uses it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      sys_reset_n  <= 1'b0;
      uart_reset_n <= 1'b0;
      ready        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sys_reset_n  <= (state_nxt == GAP) || (state_nxt == RUN);
      uart_reset_n <= (state_nxt == RUN);
      ready        <= (state_nxt == RUN);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    loss_event = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (!lock_s) begin
          state_nxt  = WAIT_LOCK;
          cnt_nxt    = '0;
          loss_event = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt  = WAIT_LOCK;
          cnt_nxt    = '0;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A clear that lands on the same edge as a loss still records that loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_flag  <= 1'b0;
      lock_loss_count <= '0;
    end else if (loss_clear) begin
      lock_loss_flag  <= loss_event;
      lock_loss_count <= LOSS_CNT_WIDTH'(loss_event);
    end else if (loss_event) begin
      lock_loss_flag <= 1'b1;
      if (!(&lock_loss_count)) lock_loss_count <= lock_loss_count + 1'b1;
    end
  end

endmodule
